// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// alu_exec_unit : execute-stage ALU, iterative shifter, valid/ready handshakes
// Optional feature macro: ALU_OVF_DETECT_EN (signed add/sub overflow). Rev 1.0
// ============================================================================
module alu_exec_unit #(
  parameter int WIDTH      = 32,
  parameter int SHIFT_STEP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       aluc,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       shamt,
  input  logic [4:0]       in_rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       out_rd,
  output logic             out_ovf
);

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;
  typedef enum logic [1:0] {SH_LL = 2'd0, SH_RL = 2'd1, SH_RA = 2'd2} shift_kind_t;

  localparam logic [5:0] STEP_MAX = 6'(SHIFT_STEP);

  state_t           state;
  shift_kind_t      kind;
  shift_kind_t      dec_kind;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] fast_result;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [4:0]       remaining;
  logic [4:0]       remaining_next;
  logic [4:0]       dec_amt;
  logic [4:0]       busy_rd;
  logic [5:0]       step;
  logic             dec_shift;
  logic             accept;
  logic             start_shift;
  logic             load_fast;
  logic             load_shift;

  assign in_ready    = (state == IDLE) && (!out_valid || out_ready) && !flush;
  assign accept      = in_valid && in_ready;
  assign sum         = a + b;
  assign diff        = a - b;
  assign start_shift = accept && dec_shift && (dec_amt != 5'd0);
  assign load_fast   = accept && !start_shift;
  assign load_shift  = (state == BUSY) && !flush && (remaining_next == 5'd0);

  always_comb begin
    dec_shift = 1'b0;
    dec_kind  = SH_LL;
    dec_amt   = shamt;
    case (aluc)
      5'd6:    begin dec_shift = 1'b1; dec_kind = SH_LL; dec_amt = shamt;  end
      5'd7:    begin dec_shift = 1'b1; dec_kind = SH_LL; dec_amt = a[4:0]; end
      5'd8:    begin dec_shift = 1'b1; dec_kind = SH_RA; dec_amt = shamt;  end
      5'd9:    begin dec_shift = 1'b1; dec_kind = SH_RA; dec_amt = a[4:0]; end
      5'd10:   begin dec_shift = 1'b1; dec_kind = SH_RL; dec_amt = shamt;  end
      5'd11:   begin dec_shift = 1'b1; dec_kind = SH_RL; dec_amt = a[4:0]; end
      default: ;
    endcase
  end

  // Shift codes only reach this path with a zero amount, so they pass b.
  always_comb begin
    fast_result = '0;
    case (aluc)
      5'd0:    fast_result = sum;
      5'd1:    fast_result = diff;
      5'd2:    fast_result = a & b;
      5'd3:    fast_result = a | b;
      5'd4:    fast_result = a ^ b;
      5'd5:    fast_result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd12:
               fast_result = b;
      5'd13:   fast_result = b << 16;
      5'd14:   fast_result = ~(a | b);
      default: fast_result = '0;
    endcase
  end

  always_comb begin
    step           = ({1'b0, remaining} > STEP_MAX) ? STEP_MAX : {1'b0, remaining};
    remaining_next = remaining - step[4:0];
    shifted        = work << step;
    case (kind)
      SH_RL:   shifted = work >> step;
      SH_RA:   shifted = $signed(work) >>> step;
      default: shifted = work << step;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      out_rd    <= '0;
      work      <= '0;
      remaining <= '0;
      kind      <= SH_LL;
      busy_rd   <= '0;
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      remaining <= '0;
    end else begin
      if (out_valid && out_ready)
        out_valid <= 1'b0;
      if (load_fast) begin
        result    <= fast_result;
        out_rd    <= in_rd;
        out_valid <= 1'b1;
      end
      if (start_shift) begin
        work      <= b;
        remaining <= dec_amt;
        kind      <= dec_kind;
        busy_rd   <= in_rd;
        state     <= BUSY;
      end
      if (state == BUSY) begin
        work      <= shifted;
        remaining <= remaining_next;
        if (load_shift) begin
          result    <= shifted;
          out_rd    <= busy_rd;
          out_valid <= 1'b1;
          state     <= IDLE;
        end
      end
    end
  end

`ifdef ALU_OVF_DETECT_EN
  logic ovf_next;
  logic ovf_q;

  always_comb begin
    ovf_next = 1'b0;
    case (aluc)
      5'd0:    ovf_next = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1]  != a[WIDTH-1]);
      5'd1:    ovf_next = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      default: ovf_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      ovf_q <= 1'b0;
    else if (load_fast)
      ovf_q <= ovf_next;
    else if (load_shift)
      ovf_q <= 1'b0;
  end

  assign out_ovf = ovf_q;
`else
  assign out_ovf = 1'b0;
`endif

endmodule
`default_nettype wire
